// File: rtl/deassert_latency_checker.sv
// deassert_latency_checker
//   Watches a req/ack pair. Each falling edge of req opens a timed window in
//   which ack must de-assert between MIN_LAT and MAX_LAT cycles after the fall.
//   Each check ends in a one-cycle pass or fail pulse. The latency of the
//   latest pass is held on lat. Pass and fail counts saturate at their maximum.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no window open; waiting for a qualified falling edge of req
//   WAIT  | window open; timer holds the edge count k since the req fall
//
// Ports
//   clk       system clock; all inputs are sampled on posedge
//   rst       asynchronous active-low reset
//   en        check enable; when low, an open window is abandoned silently
//   req       monitored signal; its falling edge starts a check
//   ack       response; must go low inside the window
//   busy      window open (registered state==WAIT)
//   pass      one-cycle pass pulse
//   fail      one-cycle fail pulse (early, timeout, or re-rise abort)
//   lat       latency of the most recent pass
//   pass_cnt  saturating pass count
//   fail_cnt  saturating fail count
module deassert_latency_checker #(
   parameter int MAX_LAT = 4,
   parameter int MIN_LAT = 1,
   parameter int CNT_W   = 8,
   localparam int LW     = $clog2(MAX_LAT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             req,
   input  logic             ack,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [LW-1:0]    lat,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   if (MAX_LAT < 1 || MIN_LAT < 0 || MIN_LAT > MAX_LAT) begin : g_bad_params
      $fatal(1, "deassert_latency_checker: need MAX_LAT>=1 and 0<=MIN_LAT<=MAX_LAT");
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [LW-1:0]    MIN_L   = LW'(MIN_LAT);
   localparam logic [LW-1:0]    MAX_L   = LW'(MAX_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             req_q, req_d;
   logic [LW-1:0]    timer_q, timer_d;
   logic             busy_q, busy_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic [LW-1:0]    lat_q, lat_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             fell;

   assign fell = req_q & ~req & en;

   always_comb begin
      state_d    = state_q;
      req_d      = req;
      timer_d    = timer_q;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      lat_d      = lat_q;

      unique case (state_q)
         S_IDLE: begin
            if (fell) begin
               if (!ack) begin
                  // ack already low on the fall edge: only legal when MIN_LAT is 0
                  if (MIN_LAT == 0) begin
                     pass_d = 1'b1;
                     lat_d  = '0;
                  end else begin
                     fail_d = 1'b1;
                  end
               end else begin
                  state_d = S_WAIT;
                  timer_d = LW'(1);
               end
            end
         end
         S_WAIT: begin
            // Priority: abandon, ack low, re-rise abort, timeout, keep counting.
            // ack low beats timeout and re-rise on the same edge.
            if (!en) begin
               state_d = S_IDLE;
            end else if (!ack) begin
               state_d = S_IDLE;
               if (timer_q >= MIN_L) begin
                  pass_d = 1'b1;
                  lat_d  = timer_q;
               end else begin
                  fail_d = 1'b1;
               end
            end else if (req) begin
               state_d = S_IDLE;
               fail_d  = 1'b1;
            end else if (timer_q == MAX_L) begin
               state_d = S_IDLE;
               fail_d  = 1'b1;
            end else begin
               timer_d = timer_q + LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d     = (state_d == S_WAIT);
      pass_cnt_d = (pass_d && pass_cnt_q != CNT_MAX) ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
      fail_cnt_d = (fail_d && fail_cnt_q != CNT_MAX) ? fail_cnt_q + CNT_W'(1) : fail_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         timer_q    <= '0;
         busy_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         lat_q      <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         timer_q    <= timer_d;
         busy_q     <= busy_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         lat_q      <= lat_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign busy     = busy_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign lat      = lat_q;
   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_deassert_latency_checker.sv
// Testbench for deassert_latency_checker. Two instances share the same inputs:
// dut uses MIN_LAT=1 and dut0 uses MIN_LAT=0, both with MAX_LAT=4 and CNT_W=8.
// A timestamp-based reference model predicts the outputs of both instances.
module tb_deassert_latency_checker;

   localparam int MAX_LAT = 4;
   localparam int CNT_W   = 8;
   localparam int LW      = $clog2(MAX_LAT + 1);
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0, req = 1'b0, ack = 1'b0;

   logic             busy_a, pass_a, fail_a;
   logic [LW-1:0]    lat_a;
   logic [CNT_W-1:0] pc_a, fc_a;
   logic             busy_b, pass_b, fail_b;
   logic [LW-1:0]    lat_b;
   logic [CNT_W-1:0] pc_b, fc_b;

   always #5 clk = ~clk;

   deassert_latency_checker #(.MAX_LAT(MAX_LAT), .MIN_LAT(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
      .busy(busy_a), .pass(pass_a), .fail(fail_a), .lat(lat_a),
      .pass_cnt(pc_a), .fail_cnt(fc_a));

   deassert_latency_checker #(.MAX_LAT(MAX_LAT), .MIN_LAT(0), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
      .busy(busy_b), .pass(pass_b), .fail(fail_b), .lat(lat_b),
      .pass_cnt(pc_b), .fail_cnt(fc_b));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model. A window is described by whether one is open and the
   // cycle number of the req fall that opened it; k is the difference in cycles.
   int  cyc;
   int  mins [2] = '{1, 0};
   bit  m_reqq;
   bit  m_open [2];
   int  m_t0   [2];
   bit  m_busy [2];
   bit  m_pass [2];
   bit  m_fail [2];
   int  m_lat  [2];
   int  m_pc   [2];
   int  m_fc   [2];

   function automatic void model_reset();
      m_reqq = 0;
      for (int i = 0; i < 2; i++) begin
         m_open[i] = 0; m_t0[i] = 0; m_busy[i] = 0; m_pass[i] = 0;
         m_fail[i] = 0; m_lat[i] = 0; m_pc[i] = 0; m_fc[i] = 0;
      end
   endfunction

   function automatic void model_edge(input bit e, input bit r, input bit a);
      bit fell;
      int k;
      cyc++;
      fell = m_reqq && !r && e;
      for (int i = 0; i < 2; i++) begin
         m_pass[i] = 0;
         m_fail[i] = 0;
         if (m_open[i]) begin
            k = cyc - m_t0[i];
            if (!e)                 m_open[i] = 0;
            else if (!a) begin
               m_open[i] = 0;
               if (k >= mins[i]) begin m_pass[i] = 1; m_lat[i] = k; end
               else m_fail[i] = 1;
            end
            else if (r)             begin m_open[i] = 0; m_fail[i] = 1; end
            else if (k == MAX_LAT)  begin m_open[i] = 0; m_fail[i] = 1; end
         end else if (fell) begin
            if (!a) begin
               if (mins[i] == 0) begin m_pass[i] = 1; m_lat[i] = 0; end
               else m_fail[i] = 1;
            end else begin
               m_open[i] = 1;
               m_t0[i]   = cyc;
            end
         end
         m_busy[i] = m_open[i];
         if (m_pass[i]) m_pc[i] = (m_pc[i] + 1 > CMAX) ? CMAX : m_pc[i] + 1;
         if (m_fail[i]) m_fc[i] = (m_fc[i] + 1 > CMAX) ? CMAX : m_fc[i] + 1;
      end
      m_reqq = r;
   endfunction

   task automatic check_model();
      chk("m1_busy", int'(busy_a), int'(m_busy[0]));
      chk("m1_pass", int'(pass_a), int'(m_pass[0]));
      chk("m1_fail", int'(fail_a), int'(m_fail[0]));
      chk("m1_lat",  int'(lat_a),  m_lat[0]);
      chk("m1_pcnt", int'(pc_a),   m_pc[0]);
      chk("m1_fcnt", int'(fc_a),   m_fc[0]);
      chk("m0_busy", int'(busy_b), int'(m_busy[1]));
      chk("m0_pass", int'(pass_b), int'(m_pass[1]));
      chk("m0_fail", int'(fail_b), int'(m_fail[1]));
      chk("m0_lat",  int'(lat_b),  m_lat[1]);
      chk("m0_pcnt", int'(pc_b),   m_pc[1]);
      chk("m0_fcnt", int'(fc_b),   m_fc[1]);
   endtask

   // Drive inputs on the falling edge, then check after the rising edge.
   task automatic step(input bit e, input bit r, input bit a);
      @(negedge clk);
      en = e; req = r; ack = a;
      @(posedge clk);
      model_edge(e, r, a);
      #1;
      check_model();
   endtask

   typedef struct {
      bit en, req, ack;
      bit busy, pass, fail;
      int lat, pc, fc;
   } vec_t;

   vec_t vecs [21];

   initial begin
      // {en,req,ack, busy,pass,fail, lat,pass_cnt,fail_cnt} for the MIN_LAT=1 instance
      vecs[0]  = '{1,1,1, 0,0,0, 0,0,0};
      vecs[1]  = '{1,0,1, 1,0,0, 0,0,0};   // t0: window opens
      vecs[2]  = '{1,0,1, 1,0,0, 0,0,0};   // k=1
      vecs[3]  = '{1,0,0, 0,1,0, 2,1,0};   // k=2 ack low -> pass, lat=2
      vecs[4]  = '{1,0,0, 0,0,0, 2,1,0};
      vecs[5]  = '{1,1,1, 0,0,0, 2,1,0};
      vecs[6]  = '{1,0,1, 1,0,0, 2,1,0};   // t0
      vecs[7]  = '{1,0,1, 1,0,0, 2,1,0};
      vecs[8]  = '{1,0,1, 1,0,0, 2,1,0};
      vecs[9]  = '{1,0,1, 1,0,0, 2,1,0};
      vecs[10] = '{1,0,1, 0,0,1, 2,1,1};   // k=4 timeout
      vecs[11] = '{1,0,1, 0,0,0, 2,1,1};
      vecs[12] = '{1,1,0, 0,0,0, 2,1,1};
      vecs[13] = '{1,0,0, 0,0,1, 2,1,2};   // ack low on fall edge -> early fail
      vecs[14] = '{1,1,1, 0,0,0, 2,1,2};
      vecs[15] = '{1,0,1, 1,0,0, 2,1,2};   // t0
      vecs[16] = '{1,1,1, 0,0,1, 2,1,3};   // re-rise at k=1 -> abort
      vecs[17] = '{1,1,1, 0,0,0, 2,1,3};
      vecs[18] = '{1,0,1, 1,0,0, 2,1,3};   // t0
      vecs[19] = '{0,0,1, 0,0,0, 2,1,3};   // en dropped -> abandon silently
      vecs[20] = '{1,0,1, 0,0,0, 2,1,3};   // req already low: no new fall

      cyc = 0;
      model_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy_a), 0);
      chk("reset_pass", int'(pass_a), 0);
      chk("reset_fail", int'(fail_a), 0);
      chk("reset_lat",  int'(lat_a),  0);
      chk("reset_pcnt", int'(pc_a),   0);
      chk("reset_fcnt", int'(fc_a),   0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 21; i++) begin
         step(vecs[i].en, vecs[i].req, vecs[i].ack);
         chk($sformatf("vec%0d_busy", i), int'(busy_a), int'(vecs[i].busy));
         chk($sformatf("vec%0d_pass", i), int'(pass_a), int'(vecs[i].pass));
         chk($sformatf("vec%0d_fail", i), int'(fail_a), int'(vecs[i].fail));
         chk($sformatf("vec%0d_lat",  i), int'(lat_a),  vecs[i].lat);
         chk($sformatf("vec%0d_pcnt", i), int'(pc_a),   vecs[i].pc);
         chk($sformatf("vec%0d_fcnt", i), int'(fc_a),   vecs[i].fc);
         if (i == 13) begin
            chk("min0_pass_on_fall", int'(pass_b), 1);
            chk("min0_lat_zero",     int'(lat_b),  0);
         end
      end

      // Asynchronous reset in the middle of an open window
      step(1, 1, 1);
      step(1, 0, 1);
      step(1, 0, 1);
      chk("pre_rst_busy", int'(busy_a), 1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("async_rst_busy", int'(busy_a), 0);
      chk("async_rst_pass", int'(pass_a), 0);
      chk("async_rst_fail", int'(fail_a), 0);
      chk("async_rst_lat",  int'(lat_a),  0);
      chk("async_rst_pcnt", int'(pc_a),   0);
      chk("async_rst_fcnt", int'(fc_a),   0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) begin
         step(1, 0, 1);
         chk("post_rst_no_busy", int'(busy_a), 0);
         chk("post_rst_no_pulse", int'(pass_a | fail_a), 0);
      end

      // Saturation of pass_cnt
      for (int n = 0; n < 260; n++) begin
         step(1, 1, 1);
         step(1, 0, 1);
         step(1, 0, 0);
      end
      chk("sat_pass_cnt", int'(pc_a), 255);
      chk("sat_fail_cnt", int'(fc_a), 0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         bit e, r, a;
         e = ($urandom_range(0, 15) != 0);
         r = ($urandom_range(0, 3) == 0) ? ~req : req;
         a = ($urandom_range(0, 2) == 0) ? ~ack : ack;
         step(e, r, a);
         chk("rand_pass_fail_excl", int'(pass_a & fail_a), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
